// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its round-robin scheduler.
// The operand, opcode, address and instruction types already exist for the
// register. The scheduler adds its depth, a request bundle and an opcode
// legality helper.
package instr_register_pkg;

  typedef logic signed [31:0] operand_t;

  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7,
    POW   = 4'd8
  } opcode_t;

  typedef logic [4:0] address_t;

  typedef struct packed {
    opcode_t     opc;
    operand_t    op_a;
    operand_t    op_b;
    logic [63:0] result;
  } instruction_t;

  // The scheduler depth must cover exactly the addressable register entries.
  localparam int SCHED_DEPTH = 32;
  localparam int SCHED_CNT_W = $clog2(SCHED_DEPTH) + 1;

  typedef struct packed {
    opcode_t  opc;
    operand_t a;
    operand_t b;
  } sched_req_t;

  // Opcodes beyond POW have no meaning to the register's ALU.
  function automatic logic opc_legal(opcode_t opc);
    return (opc <= POW);
  endfunction

endpackage

// File: rtl/instr_register_sched_if.sv
// Request, register-load and consumer signals of the instruction register
// scheduler. The master side is the requesters plus the consumer. The slave
// side is the scheduler itself.
interface instr_register_sched_if;
  import instr_register_pkg::*;

  logic                   flush;
  logic [1:0]             req_valid;
  logic [1:0]             req_ready;
  operand_t               req_operand_a [2];
  operand_t               req_operand_b [2];
  opcode_t                req_opcode    [2];
  logic                   load_en;
  operand_t               operand_a;
  operand_t               operand_b;
  opcode_t                opcode;
  address_t               write_pointer;
  address_t               read_pointer;
  logic                   out_valid;
  logic                   out_ready;
  logic [SCHED_CNT_W-1:0] occupancy;
  logic [15:0]            illegal_cnt;

  modport master (
    output flush, req_valid, req_operand_a, req_operand_b, req_opcode, out_ready,
    input  req_ready, load_en, operand_a, operand_b, opcode, write_pointer,
           read_pointer, out_valid, occupancy, illegal_cnt
  );

  modport slave (
    input  flush, req_valid, req_operand_a, req_operand_b, req_opcode, out_ready,
    output req_ready, load_en, operand_a, operand_b, opcode, write_pointer,
           read_pointer, out_valid, occupancy, illegal_cnt
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. A lone request is granted outright. A tie
// goes to the requester that did not win last time. The history moves only
// when the caller strobes advance_i, i.e. when the grant is actually consumed.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] grant_o
);

  logic last_grant_q, last_grant_d;

  // Grant selection from the current requests and the previous winner.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    grant_o = 2'b00;
    unique case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_grant_q ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
    last_grant_d = advance_i ? grant_o[1] : last_grant_q;
  end

  // Winner history. It resets to requester 1 so requester 0 takes the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) last_grant_q <= 1'b1;
    else          last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/instr_register_sched.sv
// Two-requester round-robin scheduler and circular-queue sequencer for the
// 32-entry instruction register. Accepted requests are registered onto the
// register's load port one cycle later. Entries are presented in order to a
// single consumer through read_pointer with a valid/ready handshake.
// Optional build macro ILLEGAL_OPC_DROP_EN: when it is defined, accepted
// requests with an opcode above POW are consumed, counted in illegal_cnt and
// not loaded. When it is undefined, every accept is loaded and illegal_cnt
// reads 0.
module instr_register_sched
  import instr_register_pkg::*;
#(
  parameter int DEPTH = SCHED_DEPTH,  // must equal 2**$bits(address_t)
  parameter int CNT_W = SCHED_CNT_W
) (
  input logic                   clk,
  input logic                   reset_n,
  instr_register_sched_if.slave bus
);

  logic [CNT_W-1:0] occ_q, occ_d;
  address_t         wr_ptr_q, wr_ptr_d;
  address_t         rd_ptr_q, rd_ptr_d;
  address_t         wp_q, wp_d;
  logic             load_en_q, load_en_d;
  sched_req_t       out_q, out_d;
  logic [15:0]      illegal_cnt_q, illegal_cnt_d;

  logic [1:0]       grant;
  logic [1:0]       req_ready;
  logic             full;
  logic             accept;
  logic             legal;
  logic             load_accept;
  logic             pop;
  logic             out_valid;
  logic             sel;
  sched_req_t       sel_req;
  logic [CNT_W-1:0] readable;

  rr_arbiter2 u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_i     (bus.req_valid),
    .advance_i (accept),
    .grant_o   (grant)
  );

  // Handshake decode: readiness, the granted request and the consumer view.
  always_comb begin
    full        = (occ_q == CNT_W'(DEPTH));
    req_ready   = grant & {2{~full & ~bus.flush}};
    accept      = |(bus.req_valid & req_ready);
    sel         = grant[1];
    sel_req     = '{opc: bus.req_opcode[sel],
                    a:   bus.req_operand_a[sel],
                    b:   bus.req_operand_b[sel]};
`ifdef ILLEGAL_OPC_DROP_EN
    legal       = opc_legal(sel_req.opc);
`else
    legal       = 1'b1;
`endif
    load_accept = accept & legal;
    // An entry whose register write is still in flight is counted but not yet readable.
    readable    = occ_q - CNT_W'(load_en_q);
    out_valid   = (readable != '0);
    pop         = out_valid & bus.out_ready;
  end

  // Next state for the pointers, occupancy and registered load port. Flush wins.
  always_comb begin
    occ_d         = occ_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    wp_d          = wp_q;
    out_d         = out_q;
    load_en_d     = 1'b0;
    illegal_cnt_d = illegal_cnt_q;
    if (bus.flush) begin
      occ_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (load_accept) begin
        out_d     = sel_req;
        wp_d      = wr_ptr_q;
        wr_ptr_d  = wr_ptr_q + address_t'(1);
        load_en_d = 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + address_t'(1);
      occ_d = occ_q + CNT_W'(load_accept) - CNT_W'(pop);
`ifdef ILLEGAL_OPC_DROP_EN
      if (accept && !legal && illegal_cnt_q != 16'hFFFF)
        illegal_cnt_d = illegal_cnt_q + 16'd1;
`endif
    end
  end

  // State registers. Reset drops any pending load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      wp_q          <= '0;
      out_q         <= '0;
      load_en_q     <= 1'b0;
      illegal_cnt_q <= '0;
    end else begin
      occ_q         <= occ_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      wp_q          <= wp_d;
      out_q         <= out_d;
      load_en_q     <= load_en_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  assign bus.req_ready     = req_ready;
  assign bus.load_en       = load_en_q;
  assign bus.operand_a     = out_q.a;
  assign bus.operand_b     = out_q.b;
  assign bus.opcode        = out_q.opc;
  assign bus.write_pointer = wp_q;
  assign bus.read_pointer  = rd_ptr_q;
  assign bus.out_valid     = out_valid;
  assign bus.occupancy     = occ_q;
`ifdef ILLEGAL_OPC_DROP_EN
  assign bus.illegal_cnt   = illegal_cnt_q;
`else
  assign bus.illegal_cnt   = 16'h0000;
`endif

endmodule

// File: tb/tb_instr_register_sched.sv
// Directed bench for instr_register_sched. It covers reset, a single
// requester, alternating ties, fill to full with wrap, accept and pop in the
// same cycle, flush and illegal opcodes. A small register model captures the
// load port, so popped entries can be executed and compared against
// hand-computed results.
module tb_instr_register_sched;
  import instr_register_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;

  instr_register_sched_if bus ();

  instr_register_sched dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Register model: stores whatever the scheduler loads.
  sched_req_t mem [SCHED_DEPTH];
  always @(posedge clk)
    if (bus.load_en)
      mem[bus.write_pointer] <= '{opc: bus.opcode, a: bus.operand_a, b: bus.operand_b};

  function automatic logic [63:0] exec(input sched_req_t r);
    case (r.opc)
      ADD:     return 64'(r.a + r.b);
      SUB:     return 64'(r.a - r.b);
      default: return 64'd0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush     = 1'b0;
    bus.req_valid = 2'b00;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.req_operand_a[i] = '0;
      bus.req_operand_b[i] = '0;
      bus.req_opcode[i]    = ZERO;
    end
  endtask

  task automatic set_req(input int i, input opcode_t opc, input operand_t a, input operand_t b);
    bus.req_opcode[i]    = opc;
    bus.req_operand_a[i] = a;
    bus.req_operand_b[i] = b;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    idle();
    #2;
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    reset_n = 1'b0;
    idle();
    #2;
    check("rst_load_en",   bus.load_en,       0);
    check("rst_occupancy", bus.occupancy,     0);
    check("rst_out_valid", bus.out_valid,     0);
    check("rst_wp",        bus.write_pointer, 0);
    check("rst_rp",        bus.read_pointer,  0);
    check("rst_illegal",   bus.illegal_cnt,   0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Requester 0 alone: three ADD 5,3 requests, then three pops
    set_req(0, ADD, 5, 3);
    bus.req_valid = 2'b01;
    for (int i = 0; i < 3; i++) begin
      #1 check("A_ready", bus.req_ready, 2'b01);
      tick();
      check("A_load_en",   bus.load_en,       1);
      check("A_wp",        bus.write_pointer, 64'(i));
      check("A_occupancy", bus.occupancy,     64'(i + 1));
      check("A_out_valid", bus.out_valid,     64'(i != 0));
    end
    bus.req_valid = 2'b00;
    tick();
    check("A_load_en_idle", bus.load_en,   0);
    check("A_occ_idle",     bus.occupancy, 3);
    check("A_valid_idle",   bus.out_valid, 1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check("A_pop_valid", bus.out_valid, 1);
      check("A_pop_rp",     bus.read_pointer, 64'(i));
      check("A_pop_result", exec(mem[bus.read_pointer]), 8);
      tick();
    end
    check("A_empty_occ",   bus.occupancy, 0);
    check("A_empty_valid", bus.out_valid, 0);
    tick();  // out_ready still high while empty: must be ignored
    check("A_empty_rp", bus.read_pointer, 3);
    bus.out_ready = 1'b0;

    // Both requesters valid: grants alternate starting with requester 0
    apply_reset();
    set_req(0, ADD, 10, 1);
    set_req(1, SUB, 10, 1);
    bus.req_valid = 2'b11;
    for (int k = 0; k < 8; k++) begin
      #1 check("B_grant", bus.req_ready, (k % 2 != 0) ? 2'b10 : 2'b01);
      tick();
      check("B_wp",     bus.write_pointer, 64'(k));
      check("B_opcode", bus.opcode,        (k % 2 != 0) ? SUB : ADD);
    end
    bus.req_valid = 2'b00;
    bus.flush     = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("B_flush_load_en", bus.load_en,      0);
    check("B_flush_occ",     bus.occupancy,    0);
    check("B_flush_rp",      bus.read_pointer, 0);

    // Fill to 32 with no pops, then one pop re-opens the queue and wraps
    set_req(0, ADD, 1, 2);
    bus.req_valid = 2'b01;
    repeat (32) tick();
    check("C_full_occ", bus.occupancy, 32);
    #1 check("C_full_ready", bus.req_ready, 2'b00);
    bus.out_ready = 1'b1;
    #1 check("C_pop_same_cycle_ready", bus.req_ready, 2'b00);
    check("C_full_valid", bus.out_valid, 1);
    tick();
    bus.out_ready = 1'b0;
    #1 check("C_ready_back", bus.req_ready, 2'b01);
    check("C_occ_after_pop", bus.occupancy,    31);
    check("C_rp_after_pop",  bus.read_pointer, 1);
    tick();
    bus.req_valid = 2'b00;
    check("C_wrap_wp",      bus.write_pointer, 0);
    check("C_wrap_load_en", bus.load_en,       1);
    check("C_wrap_occ",     bus.occupancy,     32);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;

    // Occupancy 1 with simultaneous accept and pop
    bus.req_valid = 2'b01;
    tick();
    bus.req_valid = 2'b00;
    tick();
    check("D_occ_one",   bus.occupancy, 1);
    check("D_valid_one", bus.out_valid, 1);
    bus.req_valid = 2'b01;
    bus.out_ready = 1'b1;
    #1 check("D_ready", bus.req_ready, 2'b01);
    tick();
    bus.req_valid = 2'b00;
    bus.out_ready = 1'b0;
    check("D_occ_kept",  bus.occupancy,     1);
    check("D_rp_adv",    bus.read_pointer,  1);
    check("D_wp_adv",    bus.write_pointer, 1);
    check("D_pending",   bus.out_valid,     0);
    tick();
    check("D_readable",  bus.out_valid,     1);

    // Flush in the cycle after an accept cancels everything
    bus.req_valid = 2'b01;
    tick();
    bus.req_valid = 2'b01;
    bus.flush     = 1'b1;
    #1 check("E_ready_in_flush", bus.req_ready, 2'b00);
    tick();
    bus.req_valid = 2'b00;
    bus.flush     = 1'b0;
    check("E_load_en", bus.load_en,      0);
    check("E_occ",     bus.occupancy,    0);
    check("E_valid",   bus.out_valid,    0);
    check("E_rp",      bus.read_pointer, 0);
    bus.req_valid = 2'b01;
    tick();
    bus.req_valid = 2'b00;
    check("E_next_wp",  bus.write_pointer, 0);
    check("E_next_occ", bus.occupancy,     1);
    tick();

    // Illegal opcode 4'hF
    set_req(0, opcode_t'(4'hF), 7, 7);
    bus.req_valid = 2'b01;
    #1 check("F_ready", bus.req_ready, 2'b01);
    tick();
    bus.req_valid = 2'b00;
`ifdef ILLEGAL_OPC_DROP_EN
    check("F_load_en", bus.load_en,     0);
    check("F_occ",     bus.occupancy,   1);
    check("F_illegal", bus.illegal_cnt, 1);
`else
    check("F_load_en", bus.load_en,       1);
    check("F_wp",      bus.write_pointer, 1);
    check("F_occ",     bus.occupancy,     2);
    check("F_illegal", bus.illegal_cnt,   0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
